// File: rtl/imm_ext_pipe.sv
// Registered immediate-generation stage: extends a raw instruction immediate
// into a DATA_W-bit ALU-B operand. Accepts one request per cycle over a
// valid/ready handshake. A PREFIX/COMBINE pair builds a full-width constant.
module imm_ext_pipe #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IMM_W    = 16,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        mode,
    input  logic [IMM_W-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext_out,
    output logic              out_err,
    output logic              pfx_pending
);

    localparam int unsigned PadW = DATA_W - IMM_W;

    typedef enum logic [2:0] {
        ModeSext    = 3'd0,
        ModeZext    = 3'd1,
        ModeUpper   = 3'd2,
        ModeBranch  = 3'd3,
        ModePrefix  = 3'd4,
        ModeCombine = 3'd5
    } mode_e;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] ext_q, ext_d;
    logic              err_q, err_d;
    logic              pfx_pending_q, pfx_pending_d;
    logic [IMM_W-1:0]  pfx_q, pfx_d;

    logic              accept;
    logic              xfer;
    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] result;
    logic              result_err;

    // Handshake: ready is combinational from out_ready so a full stage can
    // still take a new request in the cycle its result is consumed.
    always_comb begin
        in_ready = !flush && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
        xfer     = out_valid_q && out_ready;
    end

    // Operand arithmetic for every mode; PREFIX produces no result.
    always_comb begin
        zext       = DATA_W'(imm);
        sext       = DATA_W'($signed(imm));
        result     = '0;
        result_err = 1'b0;
        case (mode)
            ModeSext:    result = sext;
            ModeZext:    result = zext;
            ModeUpper:   result = zext << PadW;
            ModeBranch:  result = sext << BR_SHIFT;
            ModePrefix:  result = '0;
            ModeCombine: begin
                // Without a held prefix, COMBINE degenerates to ZEXT.
                if (pfx_pending_q) begin
                    result = (DATA_W'(pfx_q) << IMM_W) | zext;
                end else begin
                    result = zext;
                end
            end
            default:     result_err = 1'b1;
        endcase
    end

    // Next-state for the output register and prefix holding register.
    always_comb begin
        out_valid_d   = out_valid_q;
        ext_d         = ext_q;
        err_d         = err_q;
        pfx_pending_d = pfx_pending_q;
        pfx_d         = pfx_q;

        if (flush) begin
            // ext_q is deliberately left stale; out_valid gates it.
            out_valid_d   = 1'b0;
            err_d         = 1'b0;
            pfx_pending_d = 1'b0;
        end else begin
            if (xfer) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                if (mode == ModePrefix) begin
                    pfx_d         = imm;
                    pfx_pending_d = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                    ext_d       = result;
                    err_d       = result_err;
                    if (mode == ModeCombine) begin
                        pfx_pending_d = 1'b0;
                    end
                end
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            ext_q         <= '0;
            err_q         <= 1'b0;
            pfx_pending_q <= 1'b0;
            pfx_q         <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            ext_q         <= ext_d;
            err_q         <= err_d;
            pfx_pending_q <= pfx_pending_d;
            pfx_q         <= pfx_d;
        end
    end

    // Drive outputs straight from the registers.
    always_comb begin
        out_valid   = out_valid_q;
        ext_out     = ext_q;
        out_err     = err_q;
        pfx_pending = pfx_pending_q;
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe: default 32/16/2 instance
// plus a 24/8/1 instance for the parametrised mode checks.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  mode;
    logic [15:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ext_out;
    logic        out_err;
    logic        pfx_pending;

    logic        b_flush;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [2:0]  b_mode;
    logic [7:0]  b_imm;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [23:0] b_ext_out;
    logic        b_out_err;
    logic        b_pfx_pending;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    imm_ext_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mode        (mode),
        .imm         (imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ext_out     (ext_out),
        .out_err     (out_err),
        .pfx_pending (pfx_pending)
    );

    imm_ext_pipe #(
        .DATA_W   (24),
        .IMM_W    (8),
        .BR_SHIFT (1)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .flush       (b_flush),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .mode        (b_mode),
        .imm         (b_imm),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .ext_out     (b_ext_out),
        .out_err     (b_out_err),
        .pfx_pending (b_pfx_pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] m, input logic [15:0] v);
        in_valid = 1'b1;
        mode     = m;
        imm      = v;
    endtask

    task automatic breq(input logic [2:0] m, input logic [7:0] v);
        b_in_valid = 1'b1;
        b_mode     = m;
        b_imm      = v;
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        mode        = 3'd0;
        imm         = 16'h0;
        out_ready   = 1'b1;
        b_flush     = 1'b0;
        b_in_valid  = 1'b0;
        b_mode      = 3'd0;
        b_imm       = 8'h0;
        b_out_ready = 1'b1;

        tick();
        tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_ext_out", ext_out, 32'd0);
        check("rst_out_err", {31'b0, out_err}, 32'd0);
        check("rst_pfx", {31'b0, pfx_pending}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Basic modes, one result per cycle.
        req(3'd0, 16'h8001);
        tick();
        check("sext_valid", {31'b0, out_valid}, 32'd1);
        check("sext", ext_out, 32'hFFFF8001);
        check("sext_err", {31'b0, out_err}, 32'd0);
        req(3'd1, 16'h8001);
        tick();
        check("zext", ext_out, 32'h00008001);
        check("zext_valid", {31'b0, out_valid}, 32'd1);
        req(3'd2, 16'h1234);
        tick();
        check("upper", ext_out, 32'h12340000);
        req(3'd3, 16'hFFFF);
        tick();
        check("branch", ext_out, 32'hFFFFFFFC);
        check("branch_err", {31'b0, out_err}, 32'd0);

        // PREFIX then COMBINE back to back.
        req(3'd4, 16'hDEAD);
        tick();
        check("pfx_valid_drop", {31'b0, out_valid}, 32'd0);
        check("pfx_set", {31'b0, pfx_pending}, 32'd1);
        req(3'd5, 16'hBEEF);
        tick();
        check("combine_valid", {31'b0, out_valid}, 32'd1);
        check("combine", ext_out, 32'hDEADBEEF);
        check("combine_pfx_clr", {31'b0, pfx_pending}, 32'd0);
        req(3'd5, 16'h0042);
        tick();
        check("combine_nopfx", ext_out, 32'h00000042);
        in_valid = 1'b0;
        tick();
        check("drain_valid", {31'b0, out_valid}, 32'd0);

        // Back-pressure.
        out_ready = 1'b0;
        req(3'd0, 16'h7FFF);
        tick();
        check("bp_first", ext_out, 32'h00007FFF);
        req(3'd1, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
            check("bp_hold", ext_out, 32'h00007FFF);
            check("bp_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("bp_zext", ext_out, 32'h00001234);
        check("bp_zext_valid", {31'b0, out_valid}, 32'd1);

        // Illegal mode.
        req(3'd6, 16'hABCD);
        tick();
        check("illegal_ext", ext_out, 32'd0);
        check("illegal_err", {31'b0, out_err}, 32'd1);
        req(3'd0, 16'h0001);
        tick();
        check("after_illegal", ext_out, 32'h00000001);
        check("after_illegal_err", {31'b0, out_err}, 32'd0);
        in_valid = 1'b0;
        tick();

        // Flush with a pending output and a held prefix.
        out_ready = 1'b0;
        req(3'd4, 16'h5555);
        tick();
        req(3'd7, 16'h0002);
        tick();
        check("pre_flush_valid", {31'b0, out_valid}, 32'd1);
        check("pre_flush_err", {31'b0, out_err}, 32'd1);
        check("pre_flush_pfx", {31'b0, pfx_pending}, 32'd1);
        flush = 1'b1;
        req(3'd1, 16'h00FF);
        #1;
        check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_err", {31'b0, out_err}, 32'd0);
        check("flush_pfx", {31'b0, pfx_pending}, 32'd0);
        flush     = 1'b0;
        out_ready = 1'b1;
        req(3'd5, 16'h0001);
        tick();
        check("post_flush_combine", ext_out, 32'h00000001);

        // Asynchronous reset between edges.
        req(3'd4, 16'h7777);
        tick();
        req(3'd0, 16'h8000);
        tick();
        check("pre_rst_ext", ext_out, 32'hFFFF8000);
        check("pre_rst_pfx", {31'b0, pfx_pending}, 32'd1);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_ext", ext_out, 32'd0);
        check("arst_pfx", {31'b0, pfx_pending}, 32'd0);
        check("arst_err", {31'b0, out_err}, 32'd0);
        tick();
        rst = 1'b0;
        req(3'd5, 16'h0003);
        tick();
        check("post_rst_combine", ext_out, 32'h00000003);
        in_valid = 1'b0;

        // Parametrised instance: DATA_W=24, IMM_W=8, BR_SHIFT=1.
        breq(3'd3, 8'h80);
        tick();
        check("b_branch", {8'h0, b_ext_out}, 32'h00FFFF00);
        check("b_branch_valid", {31'b0, b_out_valid}, 32'd1);
        breq(3'd2, 8'hA5);
        tick();
        check("b_upper", {8'h0, b_ext_out}, 32'h00A50000);
        breq(3'd0, 8'h80);
        tick();
        check("b_sext", {8'h0, b_ext_out}, 32'h00FFFF80);
        breq(3'd1, 8'h80);
        tick();
        check("b_zext", {8'h0, b_ext_out}, 32'h00000080);
        breq(3'd4, 8'h12);
        tick();
        check("b_pfx", {31'b0, b_pfx_pending}, 32'd1);
        breq(3'd5, 8'h34);
        tick();
        check("b_combine", {8'h0, b_ext_out}, 32'h00001234);
        check("b_combine_err", {31'b0, b_out_err}, 32'd0);
        b_in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
